// File: rtl/operand_input_reg.sv
// rtl/operand_input_reg.sv - serial-to-parallel capture of a 32-bit operand pair (A then B, LSB first)
module operand_input_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             serial_in,
    input  logic             serial_valid_in,
    input  logic             clr_in,
    output logic             input_rdy,
    output logic             output_rdy,
    input  logic             output_read_in,
    output logic [WIDTH-1:0] operand_a_out,
    output logic [WIDTH-1:0] operand_b_out
);

    typedef enum logic [1:0] {
        RECV_A = 2'd0,
        RECV_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

    state_t           state;
    logic [4:0]       bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;

    assign shift_next = {serial_in, shift_reg[WIDTH-1:1]};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= RECV_A;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            operand_a_out <= '0;
            operand_b_out <= '0;
            input_rdy     <= 1'b1;
            output_rdy    <= 1'b0;
        end else begin
            unique case (state)
                RECV_A, RECV_B: begin
                    if (clr_in) begin
                        // Abort restarts at bit 0 of A; holding registers keep the last pair.
                        state     <= RECV_A;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end else if (serial_valid_in && input_rdy) begin
                        shift_reg <= shift_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (state == RECV_A) begin
                                operand_a_out <= shift_next;
                                state         <= RECV_B;
                            end else begin
                                operand_b_out <= shift_next;
                                state         <= FULL;
                                input_rdy     <= 1'b0;
                                output_rdy    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                FULL: begin
                    if (output_read_in) begin
                        state      <= RECV_A;
                        input_rdy  <= 1'b1;
                        output_rdy <= 1'b0;
                    end
                end
                default: begin
                    state      <= RECV_A;
                    bit_cnt    <= '0;
                    shift_reg  <= '0;
                    input_rdy  <= 1'b1;
                    output_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_input_reg.sv
// tb/tb_operand_input_reg.sv - randomized and directed bench for operand_input_reg against a bit-indexed frame model
module tb_operand_input_reg;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        serial_in = 1'b0;
    logic        serial_valid_in = 1'b0;
    logic        clr_in = 1'b0;
    logic        input_rdy;
    logic        output_rdy;
    logic        output_read_in = 1'b0;
    logic [31:0] operand_a_out;
    logic [31:0] operand_b_out;

    int checks = 0;
    int failures = 0;

    // Reference model: frame stored by bit position, plus completed pair.
    logic [63:0] m_frame;
    int          m_idx;
    logic        m_full;
    logic [31:0] m_a;
    logic [31:0] m_b;

    operand_input_reg #(.WIDTH(32)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .clr_in          (clr_in),
        .input_rdy       (input_rdy),
        .output_rdy      (output_rdy),
        .output_read_in  (output_read_in),
        .operand_a_out   (operand_a_out),
        .operand_b_out   (operand_b_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic b, input logic clr,
                              input logic rd, input logic rst);
        if (rst) begin
            m_frame = '0; m_idx = 0; m_full = 1'b0; m_a = '0; m_b = '0;
        end else if (m_full) begin
            if (rd) m_full = 1'b0;
        end else if (clr) begin
            m_frame = '0; m_idx = 0;
        end else if (v) begin
            m_frame[m_idx] = b;
            m_idx++;
            if (m_idx == 32) m_a = m_frame[31:0];
            if (m_idx == 64) begin
                m_b    = m_frame[63:32];
                m_full = 1'b1;
                m_idx  = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("output_rdy", {31'd0, output_rdy}, {31'd0, m_full});
        check_eq("input_rdy", {31'd0, input_rdy}, {31'd0, ~m_full});
        check_eq("operand_a", operand_a_out, m_a);
        check_eq("operand_b", operand_b_out, m_b);
    endtask

    task automatic step(input logic v, input logic b, input logic clr,
                        input logic rd, input logic rst);
        @(negedge clk_in);
        serial_valid_in = v;
        serial_in       = b;
        clr_in          = clr;
        output_read_in  = rd;
        rst_in          = rst;
        @(posedge clk_in);
        model_edge(v, b, clr, rd, rst);
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [31:0] w, input bit toggle);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, w[i], 1'b0, 1'b0, 1'b0);
            if (toggle) step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input bit toggle);
        send_word(a, toggle);
        send_word(b, toggle);
    endtask

    task automatic idle_check_full(input logic [31:0] a, input logic [31:0] b, input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq({tag, "_rdy"}, {31'd0, output_rdy}, 32'd1);
        check_eq({tag, "_a"}, operand_a_out, a);
        check_eq({tag, "_b"}, operand_b_out, b);
    endtask

    initial begin
        m_frame = '0; m_idx = 0; m_full = 1'b0; m_a = '0; m_b = '0;

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("reset_in_rdy", {31'd0, input_rdy}, 32'd1);
        check_eq("reset_out_rdy", {31'd0, output_rdy}, 32'd0);
        check_eq("reset_a", operand_a_out, 32'd0);

        // Continuous frame; output_rdy must rise the cycle after bit 64.
        send_word(32'h3F800000, 1'b0);
        for (int i = 0; i < 31; i++) step(1'b1, 1'((32'h40000000 >> i) & 1), 1'b0, 1'b0, 1'b0);
        check_eq("pre_last_rdy", {31'd0, output_rdy}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("latency_rdy", {31'd0, output_rdy}, 32'd1);
        check_eq("full_in_rdy", {31'd0, input_rdy}, 32'd0);
        check_eq("frame1_a", operand_a_out, 32'h3F800000);
        check_eq("frame1_b", operand_b_out, 32'h40000000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Toggling valid.
        send_frame(32'h3F800000, 32'h40000000, 1'b1);
        idle_check_full(32'h3F800000, 32'h40000000, "toggle");

        // Ignored traffic and clr while FULL, then clr+read together.
        for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        idle_check_full(32'h3F800000, 32'h40000000, "full_hold");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("after_read_in_rdy", {31'd0, input_rdy}, 32'd1);
        check_eq("after_read_a", operand_a_out, 32'h3F800000);
        send_frame(32'hFFFFFFFF, 32'h00000001, 1'b0);
        idle_check_full(32'hFFFFFFFF, 32'h00000001, "frame3");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Partial frame aborted with clr, plus a read ignored mid-frame.
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), 1'b0, (i == 5), 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(32'hDEADBEEF, 32'h12345678, 1'b0);
        idle_check_full(32'hDEADBEEF, 32'h12345678, "clr_frame");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-frame after 40 bits.
        for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("midrst_a", operand_a_out, 32'd0);
        check_eq("midrst_b", operand_b_out, 32'd0);
        check_eq("midrst_in_rdy", {31'd0, input_rdy}, 32'd1);
        send_frame(32'hCAFEF00D, 32'h0BADC0DE, 1'b0);
        idle_check_full(32'hCAFEF00D, 32'h0BADC0DE, "post_rst");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
